// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, mode encodings and gain compensation.
package cordic_pkg;

  localparam int unsigned CORDIC_TABLE_LEN = 32;

  localparam logic CORDIC_MODE_ROT = 1'b0;
  localparam logic CORDIC_MODE_VEC = 1'b1;

  // 1/K in Q2.30; front-ends pre-scale X by this to get unit-gain sin/cos.
  localparam logic [31:0] CORDIC_K_INV_Q30 = 32'h26DD3B6A;

  // round(atan(2^-i) * 2^30), i = 0..31
  localparam logic [31:0] CORDIC_ATAN_Q30 [0:CORDIC_TABLE_LEN-1] = '{
    32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
    32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
    32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
    32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
    32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
    32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080,
    32'h00000040, 32'h00000020, 32'h00000010, 32'h00000008,
    32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
  };

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation with valid/mode pass-through and pipeline hold.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHIFT = 0,
  parameter logic [31:0] ATAN  = 32'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic             out_valid,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z
);

  // Q2.30 table entry rescaled to the datapath's fractional width.
  localparam logic signed [31:0] ATAN_S = ATAN;
  localparam logic [WIDTH-1:0]   ATAN_W = WIDTH'(ATAN_S >>> (32 - WIDTH));

  logic             up_c;
  logic [WIDTH-1:0] x_sh_c;
  logic [WIDTH-1:0] y_sh_c;
  logic [WIDTH-1:0] x_nxt_c;
  logic [WIDTH-1:0] y_nxt_c;
  logic [WIDTH-1:0] z_nxt_c;

  // Direction decision and shift-add update; zero residue rotates clockwise.
  always_comb begin
    x_sh_c  = $signed(in_x) >>> SHIFT;
    y_sh_c  = $signed(in_y) >>> SHIFT;
    up_c    = 1'b0;
    x_nxt_c = in_x;
    y_nxt_c = in_y;
    z_nxt_c = in_z;
    if (in_mode == CORDIC_MODE_VEC) begin
      up_c = in_y[WIDTH-1];
    end else begin
      up_c = !in_z[WIDTH-1] && (in_z != '0);
    end
    if (up_c) begin
      x_nxt_c = in_x - y_sh_c;
      y_nxt_c = in_y + x_sh_c;
      z_nxt_c = in_z - ATAN_W;
    end else begin
      x_nxt_c = in_x + y_sh_c;
      y_nxt_c = in_y - x_sh_c;
      z_nxt_c = in_z + ATAN_W;
    end
  end

  // Stage register: loads on advance, holds everything (valid included) on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_mode  <= in_mode;
      out_x     <= x_nxt_c;
      out_y     <= y_nxt_c;
      out_z     <= z_nxt_c;
    end
  end

endmodule

// File: rtl/cordic_pipeline.sv
// Fully pipelined CORDIC core (rotation/vectoring per sample) with global-stall handshake.
module cordic_pipeline
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z
);

  logic             adv_c;
  logic             v_s [0:STAGES];
  logic             m_s [0:STAGES];
  logic [WIDTH-1:0] x_s [0:STAGES];
  logic [WIDTH-1:0] y_s [0:STAGES];
  logic [WIDTH-1:0] z_s [0:STAGES];

  // Whole pipe moves together whenever the output slot is free or being drained.
  assign adv_c    = out_ready | ~out_valid;
  assign in_ready = adv_c;

  assign v_s[0] = in_valid;
  assign m_s[0] = in_mode;
  assign x_s[0] = in_x;
  assign y_s[0] = in_y;
  assign z_s[0] = in_z;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    cordic_stage #(
      .WIDTH (WIDTH),
      .SHIFT (i),
      .ATAN  (CORDIC_ATAN_Q30[i])
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (adv_c),
      .in_valid  (v_s[i]),
      .in_mode   (m_s[i]),
      .in_x      (x_s[i]),
      .in_y      (y_s[i]),
      .in_z      (z_s[i]),
      .out_valid (v_s[i+1]),
      .out_mode  (m_s[i+1]),
      .out_x     (x_s[i+1]),
      .out_y     (y_s[i+1]),
      .out_z     (z_s[i+1])
    );
  end

  // Last stage registers are the result interface.
  assign out_valid = v_s[STAGES];
  assign out_mode  = m_s[STAGES];
  assign out_x     = x_s[STAGES];
  assign out_y     = y_s[STAGES];
  assign out_z     = z_s[STAGES];

endmodule

// File: tb/tb_cordic_pipeline.sv
// Self-checking bench for cordic_pipeline: random/directed samples vs an arithmetic reference.
`timescale 1ns/1ps
module tb_cordic_pipeline;

  localparam int W = 32;
  localparam int N = 16;

  typedef struct packed {
    logic        mode;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic [31:0] in_z;
  logic        out_valid;
  logic        out_ready;
  logic        out_mode;
  logic [31:0] out_x;
  logic [31:0] out_y;
  logic [31:0] out_z;

  res_t exp_q[$];
  res_t got_q[$];
  int   acc_cyc[$];
  int   out_cyc[$];
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   atan_tab [0:31];
  real  k_gain;

  cordic_pipeline #(.WIDTH(W), .STAGES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference CORDIC: iterate the textbook micro-rotation N times on 32-bit wrapped integers.
  function automatic res_t model(input logic m, input logic [31:0] x0, input logic [31:0] y0,
                                 input logic [31:0] z0);
    logic signed [31:0] xs, ys, zs, xt;
    res_t r;
    xs = x0; ys = y0; zs = z0;
    for (int i = 0; i < N; i++) begin
      xt = xs;
      if (m ? (ys < 0) : (zs > 0)) begin
        xs = xs - (ys >>> i);
        ys = ys + (xt >>> i);
        zs = zs - atan_tab[i];
      end else begin
        xs = xs + (ys >>> i);
        ys = ys - (xt >>> i);
        zs = zs + atan_tab[i];
      end
    end
    r.mode = m; r.x = xs; r.y = ys; r.z = zs;
    return r;
  endfunction

  function automatic logic [31:0] srnd(input int unsigned mag);
    return 32'($urandom_range(0, 2 * mag)) - 32'(mag);
  endfunction

  function automatic longint absdiff(input logic [31:0] a, input longint b);
    longint d;
    d = longint'($signed(a)) - b;
    return (d < 0) ? -d : d;
  endfunction

  // Random in-range sample for the given mode.
  task automatic gen_sample(input logic m, output logic [31:0] x, output logic [31:0] y,
                            output logic [31:0] z);
    if (m == 1'b0) begin
      x = srnd(32'd536870912);
      y = srnd(32'd536870912);
      z = srnd(32'd1686629713);
    end else begin
      x = 32'($urandom_range(1, 536870912));
      y = srnd(32'd536870912);
      z = srnd(32'd268435456);
    end
  endtask

  // Drive one cycle at the falling edge; log accepted inputs (with expected result) and delivered outputs.
  task automatic step(input logic v, input logic m, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] z, input logic ordy, output bit acc);
    @(negedge clk);
    in_valid = v; in_mode = m; in_x = x; in_y = y; in_z = z; out_ready = ordy;
    #1;
    acc = 1'b0;
    if (out_valid && out_ready) begin
      got_q.push_back({out_mode, out_x, out_y, out_z});
      out_cyc.push_back(cyc);
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(m, x, y, z));
      acc_cyc.push_back(cyc);
      acc = 1'b1;
    end
    cyc++;
  endtask

  task automatic drain(input int budget);
    bit acc;
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
      n++;
    end
    if (got_q.size() < exp_q.size()) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout got %0d results, required %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic clear_logs();
    exp_q.delete(); got_q.delete(); acc_cyc.delete(); out_cyc.delete();
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_x = '0; in_y = '0; in_z = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++;
    if ({out_mode, out_x, out_y, out_z} !== 97'd0) begin
      n_bad++; $display("FAIL reset_outputs got %h/%h/%h/%b want 0", out_x, out_y, out_z, out_mode);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_rotation();
    bit acc;
    clear_logs();
    step(1'b1, 1'b0, 32'h26DD3B6A, 32'h0, 32'd562214046, 1'b1, acc);
    drain(40);
    if (got_q.size() > 0) begin
      n_cmp++;
      if (got_q[0] !== exp_q[0]) begin
        n_bad++; $display("FAIL rot_exact got %h want %h", got_q[0], exp_q[0]);
      end
      n_cmp++;
      if (out_cyc[0] - acc_cyc[0] !== N) begin
        n_bad++; $display("FAIL rot_latency got %0d want %0d", out_cyc[0] - acc_cyc[0], N);
      end
      n_cmp++;
      if (absdiff(got_q[0].x, 929887697) > 65536) begin
        n_bad++; $display("FAIL rot_cos got %0d want 929887697", $signed(got_q[0].x));
      end
      n_cmp++;
      if (absdiff(got_q[0].y, 536870912) > 65536) begin
        n_bad++; $display("FAIL rot_sin got %0d want 536870912", $signed(got_q[0].y));
      end
      n_cmp++;
      if (absdiff(got_q[0].z, 0) >= 65536) begin
        n_bad++; $display("FAIL rot_resid got %0d want ~0", $signed(got_q[0].z));
      end
    end
  endtask

  task automatic test_vectoring();
    bit acc;
    real mag;
    clear_logs();
    mag = $sqrt(2.0) * 0.5 * k_gain * 1073741824.0;
    step(1'b1, 1'b1, 32'h20000000, 32'h20000000, 32'h0, 1'b1, acc);
    drain(40);
    if (got_q.size() > 0) begin
      n_cmp++;
      if (got_q[0] !== exp_q[0]) begin
        n_bad++; $display("FAIL vec_exact got %h want %h", got_q[0], exp_q[0]);
      end
      n_cmp++;
      if (absdiff(got_q[0].x, longint'(mag)) > 131072) begin
        n_bad++; $display("FAIL vec_mag got %0d want %0d", $signed(got_q[0].x), longint'(mag));
      end
      n_cmp++;
      if (absdiff(got_q[0].y, 0) > 65536) begin
        n_bad++; $display("FAIL vec_y got %0d want ~0", $signed(got_q[0].y));
      end
      n_cmp++;
      if (absdiff(got_q[0].z, 843314857) > 65536) begin
        n_bad++; $display("FAIL vec_atan got %0d want 843314857", $signed(got_q[0].z));
      end
      n_cmp++;
      if (got_q[0].mode !== 1'b1) begin
        n_bad++; $display("FAIL vec_mode got %b want 1", got_q[0].mode);
      end
    end
  endtask

  task automatic test_streaming();
    bit acc;
    logic [31:0] x, y, z;
    clear_logs();
    for (int i = 0; i < 40; i++) begin
      gen_sample(1'(i % 2), x, y, z);
      step(1'b1, 1'(i % 2), x, y, z, 1'b1, acc);
    end
    drain(60);
    n_cmp++;
    if (got_q.size() !== 40) begin n_bad++; $display("FAIL stream_count got %0d want 40", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL stream_data[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
      n_cmp++;
      if (out_cyc[i] !== acc_cyc[i] + N) begin
        n_bad++; $display("FAIL stream_timing[%0d] got cycle %0d want %0d", i, out_cyc[i], acc_cyc[i] + N);
      end
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    int k;
    logic sm [0:19];
    logic [31:0] sx [0:19];
    logic [31:0] sy [0:19];
    logic [31:0] sz [0:19];
    res_t snap;
    clear_logs();
    for (int i = 0; i < 20; i++) begin
      sm[i] = 1'($urandom_range(0, 1));
      gen_sample(sm[i], sx[i], sy[i], sz[i]);
    end
    k = 0;
    snap = '0;
    for (int t = 0; t < 30; t++) begin
      if (k < 20) step(1'b1, sm[k], sx[k], sy[k], sz[k], !(t >= 18 && t < 23), acc);
      else        step(1'b0, 1'b0, '0, '0, '0, !(t >= 18 && t < 23), acc);
      if (acc) k++;
      if (t >= 18 && t < 23) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready t=%0d got %b want 0", t, in_ready); end
      end
      if (t == 18) snap = {out_mode, out_x, out_y, out_z};
      if (t > 18 && t <= 23) begin
        n_cmp++;
        if ({out_mode, out_x, out_y, out_z} !== snap) begin
          n_bad++; $display("FAIL bp_hold t=%0d got %h want %h", t, {out_mode, out_x, out_y, out_z}, snap);
        end
      end
    end
    drain(60);
    n_cmp++;
    if (got_q.size() !== 20) begin n_bad++; $display("FAIL bp_count got %0d want 20", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL bp_data[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_bubbles();
    bit acc;
    logic [31:0] x, y, z;
    bit pat [0:3];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      gen_sample(1'b0, x, y, z);
      step(pat[i], 1'b0, x, y, 32'h0, 1'b1, acc);
    end
    for (int i = 0; i < 4; i++) begin
      gen_sample(1'b1, x, y, z);
      step(pat[i], 1'b1, x, 32'h0, z, 1'b1, acc);
    end
    drain(40);
    n_cmp++;
    if (got_q.size() !== 4) begin n_bad++; $display("FAIL bub_count got %0d want 4", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL bub_data[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    if (out_cyc.size() == 4) begin
      n_cmp++;
      if (out_cyc[1] - out_cyc[0] !== 3 || out_cyc[3] - out_cyc[2] !== 3) begin
        n_bad++;
        $display("FAIL bub_gaps got %0d,%0d want 3,3", out_cyc[1] - out_cyc[0], out_cyc[3] - out_cyc[2]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    bit acc;
    logic [31:0] x, y, z;
    clear_logs();
    for (int i = 0; i < 10; i++) begin
      gen_sample(1'(i % 2), x, y, z);
      step(1'b1, 1'(i % 2), x, y, z, 1'b1, acc);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    n_cmp++;
    if ({out_mode, out_x, out_y, out_z} !== 97'd0) begin
      n_bad++; $display("FAIL mid_rst_outputs got %h/%h/%h/%b want 0", out_x, out_y, out_z, out_mode);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
    n_cmp++;
    if (got_q.size() !== 0) begin n_bad++; $display("FAIL mid_rst_ghost got %0d outputs want 0", got_q.size()); end
    gen_sample(1'b0, x, y, z);
    step(1'b1, 1'b0, x, y, z, 1'b1, acc);
    drain(40);
    if (got_q.size() == 1) begin
      n_cmp++;
      if (out_cyc[0] - acc_cyc[0] !== N) begin
        n_bad++; $display("FAIL mid_rst_latency got %0d want %0d", out_cyc[0] - acc_cyc[0], N);
      end
      n_cmp++;
      if (got_q[0] !== exp_q[0]) begin
        n_bad++; $display("FAIL mid_rst_data got %h want %h", got_q[0], exp_q[0]);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    k_gain = 1.0;
    for (int i = 0; i < 32; i++) atan_tab[i] = $rtoi($atan(2.0 ** (-i)) * 1073741824.0 + 0.5);
    for (int i = 0; i < N; i++) k_gain = k_gain * $sqrt(1.0 + 2.0 ** (-2 * i));
    test_reset();
    test_rotation();
    test_vectoring();
    test_streaming();
    test_backpressure();
    test_bubbles();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
